// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory loader
// and the benches that drive it.
package imem_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BYTE_W      = 8;

    // RV32 R-type major opcode, handy for building bench programs.
    localparam logic [6:0] OPCODE_RTYPE = 7'h33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host word stream plus instruction memory byte write port.
// master = host/bench side, slave = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 5
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              word_valid;
    logic [31:0]       word_data;
    logic              word_last;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [31:0]       checksum;

    modport master (
        output start, base_addr, word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata,
        input  busy, done, overflow, checksum
    );

    modport slave (
        input  start, base_addr, word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata,
        output busy, done, overflow, checksum
    );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: serializes 32-bit words into little-endian byte writes.
// Optional word XOR checksum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 5
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              overflow_q, overflow_d;

    // Next-state logic for the session FSM, address counter and byte index.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        word_d     = word_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d     = {bus.base_addr[ADDR_W-1:2], 2'b00};
                    overflow_d = 1'b0;
                    idx_d      = 2'd0;
                    state_d    = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.word_valid) begin
                    word_d  = bus.word_data;
                    last_d  = bus.word_last;
                    idx_d   = 2'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + 1'b1;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        // Never wrap to address 0: stop and flag it.
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            idx_q      <= 2'd0;
            word_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    // Fold each accepted word into the checksum; start clears it.
    always_comb begin
        chk_d = chk_q;
        if (state_q == ST_IDLE && bus.start) begin
            chk_d = '0;
        end else if (state_q == ST_ACCEPT && bus.word_valid) begin
            chk_d = chk_q ^ bus.word_data;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign bus.checksum = chk_q;
`else
    assign bus.checksum = '0;
`endif

    // Outputs decode from registers only.
    assign bus.word_ready = (state_q == ST_ACCEPT);
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = (state_q == ST_WRITE)
                          ? word_q[{idx_q, 3'b000} +: BYTE_W]
                          : 8'h00;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.overflow   = overflow_q;

endmodule
